pfpu_fcmp: RTL and testbench

PFPU_FCMP -- requirements
Module: pfpu_fcmp

---
 rtl/pfpu_fcmp.sv | 161 ++++++++++++++++
 tb/tb_pfpu_fcmp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pfpu_fcmp.sv
// pfpu_fcmp: IEEE-754 single-precision compare / min / max unit.
// Compare modes return TRUE_VAL or zero, MIN/MAX return an operand bit-exact.
// The result passes through a LATENCY-deep valid-qualified pipeline.
module pfpu_fcmp #(
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] TRUE_VAL = 32'h3f800000
) (
  input  logic        sys_clk,
  input  logic        alu_rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  mode,
  input  logic        valid_i,
  output logic [31:0] r,
  output logic        valid_o,
  output logic        unord_o,
  output logic        busy
);

  typedef enum logic [2:0] {
    MODE_GT  = 3'b000,
    MODE_EQ  = 3'b001,
    MODE_GE  = 3'b010,
    MODE_MIN = 3'b011,
    MODE_MAX = 3'b100
  } mode_e;

  localparam logic [31:0] QNAN     = 32'h7fc00000;
  localparam logic [31:0] POS_ZERO = 32'h00000000;
  localparam logic [31:0] NEG_ZERO = 32'h80000000;

  logic        a_nan, b_nan, any_nan, both_zero;
  logic        mag_lt, mag_gt;
  logic        a_lt_b, a_gt_b, a_eq_b;
  logic [31:0] min_val, max_val;
  logic [31:0] res_d;
  logic        unord_d;

  assign a_nan     = (&a[30:23]) && (|a[22:0]);
  assign b_nan     = (&b[30:23]) && (|b[22:0]);
  assign any_nan   = a_nan || b_nan;
  assign both_zero = ~(|a[30:0]) && ~(|b[30:0]);
  assign mag_lt    = a[30:0] < b[30:0];
  assign mag_gt    = a[30:0] > b[30:0];

  // Sign-magnitude ordering of two non-NaN values; +0 and -0 are equal.
  always_comb begin
    a_lt_b = 1'b0;
    a_gt_b = 1'b0;
    if (both_zero) begin
      a_lt_b = 1'b0;
      a_gt_b = 1'b0;
    end else if (a[31] != b[31]) begin
      a_lt_b = a[31];
      a_gt_b = b[31];
    end else if (!a[31]) begin
      a_lt_b = mag_lt;
      a_gt_b = mag_gt;
    end else begin
      a_lt_b = mag_gt;
      a_gt_b = mag_lt;
    end
  end

  assign a_eq_b = !a_lt_b && !a_gt_b;

  // MIN/MAX selection including NaN passthrough and signed-zero handling.
  always_comb begin
    min_val = a;
    max_val = a;
    if (a_nan && b_nan) begin
      min_val = QNAN;
      max_val = QNAN;
    end else if (a_nan) begin
      min_val = b;
      max_val = b;
    end else if (b_nan) begin
      min_val = a;
      max_val = a;
    end else if (both_zero) begin
      min_val = (a[31] || b[31]) ? NEG_ZERO : POS_ZERO;
      max_val = (a[31] && b[31]) ? NEG_ZERO : POS_ZERO;
    end else begin
      min_val = a_gt_b ? b : a;
      max_val = a_lt_b ? b : a;
    end
  end

  // Mode decode into the stage-1 result and unordered flag.
  always_comb begin
    res_d   = '0;
    unord_d = 1'b0;
    case (mode_e'(mode))
      MODE_GT: begin
        res_d   = (!any_nan && a_gt_b) ? TRUE_VAL : '0;
        unord_d = any_nan;
      end
      MODE_EQ: begin
        res_d   = (!any_nan && a_eq_b) ? TRUE_VAL : '0;
        unord_d = any_nan;
      end
      MODE_GE: begin
        res_d   = (!any_nan && !a_lt_b) ? TRUE_VAL : '0;
        unord_d = any_nan;
      end
      MODE_MIN: begin
        res_d   = min_val;
        unord_d = any_nan;
      end
      MODE_MAX: begin
        res_d   = max_val;
        unord_d = any_nan;
      end
      default: begin
        res_d   = '0;
        unord_d = 1'b0;
      end
    endcase
  end

  logic        v_q [LATENCY];
  logic [31:0] d_q [LATENCY];
  logic        u_q [LATENCY];

  // Valid-qualified delay line; data stages only load behind a valid stage.
  always_ff @(posedge sys_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
        u_q[i] <= 1'b0;
      end
    end else begin
      v_q[0] <= valid_i;
      if (valid_i) begin
        d_q[0] <= res_d;
        u_q[0] <= unord_d;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) begin
          d_q[i] <= d_q[i-1];
          u_q[i] <= u_q[i-1];
        end
      end
    end
  end

  // Busy whenever any stage, including the output stage, holds an operation.
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      busy = busy | v_q[i];
    end
  end

  assign valid_o = v_q[LATENCY-1];
  assign r       = d_q[LATENCY-1];
  assign unord_o = u_q[LATENCY-1];

endmodule

// File: tb/tb_pfpu_fcmp.sv
// tb_pfpu_fcmp: three instances (LATENCY 1, 3, 4) share one stimulus stream;
// a cycle-indexed issue history predicts valid_o/r/unord_o/busy for each.
module tb_pfpu_fcmp;

  logic        sys_clk = 1'b0;
  logic        alu_rst_n;
  logic [31:0] a, b;
  logic [2:0]  mode;
  logic        valid_i;
  logic [31:0] r1, r3, r4;
  logic        v1, v3, v4, u1, u3, u4, b1, b3, b4;

  always #5 sys_clk = ~sys_clk;

  pfpu_fcmp #(.LATENCY(1), .TRUE_VAL(32'h3f800000)) dut1 (
    .sys_clk(sys_clk), .alu_rst_n(alu_rst_n), .a(a), .b(b), .mode(mode),
    .valid_i(valid_i), .r(r1), .valid_o(v1), .unord_o(u1), .busy(b1));
  pfpu_fcmp #(.LATENCY(3), .TRUE_VAL(32'h3f800000)) dut3 (
    .sys_clk(sys_clk), .alu_rst_n(alu_rst_n), .a(a), .b(b), .mode(mode),
    .valid_i(valid_i), .r(r3), .valid_o(v3), .unord_o(u3), .busy(b3));
  pfpu_fcmp #(.LATENCY(4), .TRUE_VAL(32'h3f800000)) dut4 (
    .sys_clk(sys_clk), .alu_rst_n(alu_rst_n), .a(a), .b(b), .mode(mode),
    .valid_i(valid_i), .r(r4), .valid_o(v4), .unord_o(u4), .busy(b4));

  localparam logic [31:0] TV = 32'h3f800000;

  int checks = 0;
  int errors = 0;
  int n = 100;

  // History of operations accepted at each rising edge (ring of 16).
  logic        hv [16];
  logic [31:0] hr [16];
  logic        hu [16];
  logic [31:0] hold_r [3];
  logic        hold_u [3];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  mode;
    logic [31:0] exp_r;
    logic        exp_u;
  } vec_t;

  vec_t vecs [16];

  // Reference: map sign-magnitude floats onto signed integers so that
  // ordinary integer comparison gives the float order (+0 == -0).
  function automatic logic [32:0] model(logic [31:0] x, logic [31:0] y, logic [2:0] m);
    logic xn, yn;
    int kx, ky;
    logic [31:0] res;
    xn = (x[30:23] == 8'hff) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hff) && (y[22:0] != 0);
    kx = x[31] ? -int'({1'b0, x[30:0]}) : int'({1'b0, x[30:0]});
    ky = y[31] ? -int'({1'b0, y[30:0]}) : int'({1'b0, y[30:0]});
    if (m > 3'd4) return {1'b0, 32'h0};
    res = 32'h0;
    if (m <= 3'd2) begin
      if (!(xn || yn)) begin
        if (m == 3'd0 && kx > ky)  res = TV;
        if (m == 3'd1 && kx == ky) res = TV;
        if (m == 3'd2 && kx >= ky) res = TV;
      end
    end else if (xn && yn) res = 32'h7fc00000;
    else if (xn) res = y;
    else if (yn) res = x;
    else if (kx == ky && kx == 0) begin
      if (m == 3'd3) res = (x[31] || y[31]) ? 32'h80000000 : 32'h0;
      else           res = (x[31] && y[31]) ? 32'h80000000 : 32'h0;
    end else if (kx == ky) res = x;
    else if (m == 3'd3) res = (kx < ky) ? x : y;
    else                res = (kx > ky) ? x : y;
    return {xn || yn, res};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] pool [12];
    pool = '{32'h00000000, 32'h80000000, 32'h3f800000, 32'hbf800000,
             32'h7f800000, 32'hff800000, 32'h7fc00000, 32'h7f800001,
             32'h00000001, 32'h80000001, 32'hffffffff, 32'h40400000};
    if ($urandom_range(9) < 6) return pool[$urandom_range(11)];
    return $urandom;
  endfunction

  task automatic chk(string name, int lat, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s L=%0d edge=%0d got=%h expected=%h", name, lat, n, got, exp);
    end
  endtask

  task automatic check_dut(int idx, int lat, logic [31:0] rr, logic vv, logic uu, logic bb);
    int m;
    logic ev, eb;
    m  = n - lat + 1;
    ev = hv[m % 16];
    eb = 1'b0;
    for (int k = 0; k < lat; k++) eb |= hv[(n - k) % 16];
    if (ev) begin
      hold_r[idx] = hr[m % 16];
      hold_u[idx] = hu[m % 16];
    end
    chk("valid_o", lat, {31'h0, vv}, {31'h0, ev});
    chk("r",       lat, rr,          hold_r[idx]);
    chk("unord_o", lat, {31'h0, uu}, {31'h0, hold_u[idx]});
    chk("busy",    lat, {31'h0, bb}, {31'h0, eb});
  endtask

  task automatic check_all();
    check_dut(0, 1, r1, v1, u1, b1);
    check_dut(1, 3, r3, v3, u3, b3);
    check_dut(2, 4, r4, v4, u4, b4);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      hv[i] = 1'b0;
      hr[i] = '0;
      hu[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      hold_r[i] = '0;
      hold_u[i] = 1'b0;
    end
  endtask

  task automatic step(logic v, logic [31:0] aa, logic [31:0] bb, logic [2:0] mm,
                      logic [31:0] er, logic eu);
    a = aa; b = bb; mode = mm; valid_i = v;
    @(posedge sys_clk);
    #1;
    n++;
    hv[n % 16] = v && alu_rst_n;
    hr[n % 16] = er;
    hu[n % 16] = eu;
    check_all();
  endtask

  task automatic step_model(logic v, logic [31:0] aa, logic [31:0] bb, logic [2:0] mm);
    logic [32:0] e;
    e = model(aa, bb, mm);
    step(v, aa, bb, mm, e[31:0], e[32]);
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) step_model(1'b0, pick(), pick(), 3'($urandom_range(7)));
  endtask

  // Asynchronous reset pulse away from the clock edge, held over one edge.
  task automatic reset_pulse();
    #2;
    alu_rst_n = 1'b0;
    #1;
    clear_model();
    check_all();
    step_model(1'b1, 32'h3f800000, 32'h0, 3'd0);
    alu_rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{32'h3f800000, 32'h40000000, 3'd0, 32'h0,        1'b0};
    vecs[1]  = '{32'h3f800000, 32'h40000000, 3'd2, 32'h0,        1'b0};
    vecs[2]  = '{32'h3f800000, 32'h40000000, 3'd3, 32'h3f800000, 1'b0};
    vecs[3]  = '{32'hc0000000, 32'hbf800000, 3'd0, 32'h0,        1'b0};
    vecs[4]  = '{32'hc0000000, 32'hbf800000, 3'd4, 32'hbf800000, 1'b0};
    vecs[5]  = '{32'hc0000000, 32'hbf800000, 3'd3, 32'hc0000000, 1'b0};
    vecs[6]  = '{32'h80000000, 32'h00000000, 3'd1, TV,           1'b0};
    vecs[7]  = '{32'h80000000, 32'h00000000, 3'd0, 32'h0,        1'b0};
    vecs[8]  = '{32'h80000000, 32'h00000000, 3'd3, 32'h80000000, 1'b0};
    vecs[9]  = '{32'h80000000, 32'h00000000, 3'd4, 32'h00000000, 1'b0};
    vecs[10] = '{32'h7fc00001, 32'h40400000, 3'd4, 32'h40400000, 1'b1};
    vecs[11] = '{32'h7fc00001, 32'h7fc00001, 3'd3, 32'h7fc00000, 1'b1};
    vecs[12] = '{32'h7f800000, 32'h7f7fffff, 3'd2, TV,           1'b0};
    vecs[13] = '{32'h7fc00001, 32'h7fc00001, 3'd1, 32'h0,        1'b1};
    vecs[14] = '{32'h3f800000, 32'h3f800000, 3'd5, 32'h0,        1'b0};
    vecs[15] = '{32'h00000000, 32'h80000000, 3'd3, 32'h80000000, 1'b0};

    alu_rst_n = 1'b0;
    valid_i = 1'b0; a = '0; b = '0; mode = '0;
    clear_model();
    #1;
    check_all();
    step_model(1'b1, 32'h3f800000, 32'h0, 3'd0);
    step_model(1'b0, 32'h0, 32'h0, 3'd0);
    alu_rst_n = 1'b1;

    // Directed vectors back-to-back, first on the first edge after release.
    for (int i = 0; i < 16; i++)
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp_r, vecs[i].exp_u);
    idle(5);

    // Three ops, one-cycle gap, three ops: gap must reappear at the output.
    for (int i = 0; i < 3; i++) step_model(1'b1, pick(), pick(), 3'($urandom_range(4)));
    step_model(1'b0, pick(), pick(), 3'd3);
    for (int i = 0; i < 3; i++) step_model(1'b1, pick(), pick(), 3'($urandom_range(4)));
    idle(6);

    // Two ops in flight then reset: nothing may emerge afterwards.
    step_model(1'b1, 32'h40000000, 32'h3f800000, 3'd0);
    step_model(1'b1, 32'h40000000, 32'h3f800000, 3'd4);
    reset_pulse();
    idle(6);

    // Randomized traffic with bubbles and one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      step_model(($urandom_range(3) != 0), pick(), pick(), 3'($urandom_range(7)));
      if (i == 200) reset_pulse();
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
